// File: rtl/chacha_ks_scheduler.sv
// Keystream scheduler for a ChaCha block core: requests one 64-byte block per
// counter value and streams bytes through a serialiser until the message ends.
module chacha_ks_scheduler #(
   parameter int unsigned LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] msg_len,
   input  logic [31:0]      init_ctr,
   output logic             busy,
   output logic             core_start,
   output logic [31:0]      core_ctr,
   input  logic             core_done,
   output logic             ser_load,
   output logic             ser_advance,
   output logic             ks_valid,
   input  logic             ks_ready,
   output logic             ks_last,
   output logic             done,
   output logic             err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GEN,
      S_LOAD,
      S_STREAM,
      S_DONE,
      S_ERR
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [LEN_W-1:0] r_rem;
   logic [5:0]       r_bcnt;
   logic [31:0]      r_blk_ctr;
   logic             r_gen_first;
   logic             w_hs;
   logic             w_rem_one;
   logic             w_blk_end;
   logic             w_ctr_max;

   assign w_rem_one = (r_rem == LEN_W'(1));
   assign w_blk_end = (r_bcnt == 6'd63);
   assign w_ctr_max = (r_blk_ctr == '1);
   assign w_hs      = ks_valid & ks_ready;

   always_comb begin
      w_next      = r_state;
      busy        = (r_state != S_IDLE);
      core_start  = (r_state == S_GEN) && r_gen_first;
      core_ctr    = r_blk_ctr;
      ser_load    = (r_state == S_LOAD);
      ks_valid    = (r_state == S_STREAM);
      ser_advance = ks_valid & ks_ready;
      ks_last     = ks_valid & w_rem_one;
      done        = (r_state == S_DONE) || (r_state == S_ERR);
      err         = (r_state == S_ERR);
      case (r_state)
         S_IDLE: begin
            if (start) w_next = (msg_len == '0) ? S_DONE : S_GEN;
         end
         // core_done in the core_start cycle belongs to no request of ours
         S_GEN: begin
            if (!r_gen_first && core_done) w_next = S_LOAD;
         end
         S_LOAD: w_next = S_STREAM;
         S_STREAM: begin
            if (w_hs) begin
               if (w_rem_one)      w_next = S_DONE;
               else if (w_blk_end) w_next = w_ctr_max ? S_ERR : S_GEN;
            end
         end
         S_DONE:  w_next = S_IDLE;
         S_ERR:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_rem       <= '0;
         r_bcnt      <= '0;
         r_blk_ctr   <= '0;
         r_gen_first <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_gen_first <= (w_next == S_GEN) && (r_state != S_GEN);
         if (r_state == S_IDLE && start && msg_len != '0) begin
            r_rem     <= msg_len;
            r_blk_ctr <= init_ctr;
            r_bcnt    <= '0;
         end
         if (r_state == S_STREAM && w_hs) begin
            r_rem  <= r_rem - LEN_W'(1);
            r_bcnt <= r_bcnt + 6'd1;
            if (!w_rem_one && w_blk_end && !w_ctr_max) r_blk_ctr <= r_blk_ctr + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_chacha_ks_scheduler.sv
// Directed bench for chacha_ks_scheduler: a behavioural core responder and
// per-cycle event counters, checked against hand-computed expectations.
module tb_chacha_ks_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] msg_len;
   logic [31:0] init_ctr;
   logic        busy, core_start, core_done, ser_load, ser_advance;
   logic        ks_valid, ks_ready, ks_last, done, err;
   logic [31:0] core_ctr;

   chacha_ks_scheduler #(.LEN_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .msg_len(msg_len), .init_ctr(init_ctr),
      .busy(busy), .core_start(core_start), .core_ctr(core_ctr), .core_done(core_done),
      .ser_load(ser_load), .ser_advance(ser_advance), .ks_valid(ks_valid),
      .ks_ready(ks_ready), .ks_last(ks_last), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   int cyc = 0;
   int core_delay, resp;
   bit toggle, inject, injected;
   int n_cs, n_load, n_valid, n_adv, n_done, n_err, n_errdone, last_at;
   int start_cyc, cd_cyc, first_valid_cyc, last_valid_cyc, last_adv_cyc, done_cyc;
   logic [31:0] cs_ctr [4];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_counts();
      n_cs = 0; n_load = 0; n_valid = 0; n_adv = 0; n_done = 0; n_err = 0;
      n_errdone = 0; last_at = 0; cd_cyc = -1; first_valid_cyc = -1;
      last_valid_cyc = -1; last_adv_cyc = -1; done_cyc = -1; resp = 0;
      injected = 0;
      for (int i = 0; i < 4; i++) cs_ctr[i] = '0;
   endtask

   // one clock: drive this cycle's inputs, then observe the DUT outputs
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      start     = 1'b0;
      core_done = 1'b0;
      if (core_start) resp = core_delay;
      else if (resp > 0) begin
         resp--;
         if (resp == 0) begin
            core_done = 1'b1;
            if (cd_cyc < 0) cd_cyc = cyc;
         end
      end
      ks_ready = toggle ? ~ks_ready : 1'b1;
      if (inject && !injected && n_adv == 10) begin
         start = 1'b1; msg_len = 16'd3; init_ctr = 32'd99; injected = 1;
      end
      #1;
      if (core_start) begin
         if (n_cs < 4) cs_ctr[n_cs] = core_ctr;
         n_cs++;
      end
      if (ser_load) n_load++;
      if (ks_valid) begin
         n_valid++;
         if (first_valid_cyc < 0) first_valid_cyc = cyc;
         last_valid_cyc = cyc;
      end
      if (ser_advance) begin
         n_adv++;
         last_adv_cyc = cyc;
         if (ks_last) last_at = n_adv;
      end
      if (done) begin n_done++; done_cyc = cyc; end
      if (err) n_err++;
      if (err && done) n_errdone++;
   endtask

   task automatic run_msg(input int len, input logic [31:0] ctr, input int d,
                          input bit tog, input bit inj);
      clear_counts();
      core_delay = d; toggle = tog; inject = inj;
      msg_len = 16'(len); init_ctr = ctr; start = 1'b1; start_cyc = cyc;
      for (int i = 0; i < 3000 && n_done == 0; i++) step();
      check("finished", (n_done > 0) ? 1 : 0, 1);
      step();
      check("idle_after", busy, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; msg_len = '0; init_ctr = '0;
      core_done = 1'b0; ks_ready = 1'b1; toggle = 0; inject = 0; core_delay = 5;
      clear_counts();
      repeat (3) step();
      check("rst_outs", {busy, core_start, ser_load, ser_advance, ks_valid, ks_last, done, err}, 0);
      check("rst_ctr", core_ctr, 0);
      rst = 1'b0;

      // one full block, with a stray start mid-stream that must be ignored
      run_msg(64, 32'd1, 5, 0, 1);
      check("t1_cs", n_cs, 1);
      check("t1_ctr", cs_ctr[0], 1);
      check("t1_load", n_load, 1);
      check("t1_valid", n_valid, 64);
      check("t1_adv", n_adv, 64);
      check("t1_last", last_at, 64);
      check("t1_lat", first_valid_cyc - cd_cyc, 2);
      check("t1_done_at", done_cyc - last_adv_cyc, 1);
      check("t1_err", n_err, 0);

      // three blocks, partial final block
      run_msg(130, 32'd7, 5, 0, 0);
      check("t2_cs", n_cs, 3);
      check("t2_ctr0", cs_ctr[0], 7);
      check("t2_ctr1", cs_ctr[1], 8);
      check("t2_ctr2", cs_ctr[2], 9);
      check("t2_load", n_load, 3);
      check("t2_adv", n_adv, 130);
      check("t2_last", last_at, 130);
      check("t2_done", n_done, 1);

      // empty message
      run_msg(0, 32'd4, 5, 0, 0);
      check("t3_cs", n_cs, 0);
      check("t3_valid", n_valid, 0);
      check("t3_done_at", done_cyc - start_cyc, 1);

      // back-pressure, fast core
      run_msg(10, 32'd2, 1, 1, 0);
      check("t4_adv", n_adv, 10);
      check("t4_last", last_at, 10);
      check("t4_contig", last_valid_cyc - first_valid_cyc + 1, n_valid);
      check("t4_lat", first_valid_cyc - cd_cyc, 2);
      check("t4_done_at", done_cyc - last_adv_cyc, 1);
      toggle = 0;

      // counter exhaustion
      run_msg(100, 32'hFFFF_FFFF, 5, 0, 0);
      check("t5_adv", n_adv, 64);
      check("t5_errdone", n_errdone, 1);
      check("t5_done", n_done, 1);
      check("t5_cs", n_cs, 1);
      check("t5_nowrap", core_ctr, 32'hFFFF_FFFF);

      // reset mid-stream, then restart on the very next cycle
      clear_counts();
      core_delay = 5; inject = 0;
      msg_len = 16'd64; init_ctr = 32'd3; start = 1'b1;
      for (int i = 0; i < 500 && n_adv < 20; i++) step();
      check("t6_reach20", n_adv, 20);
      rst = 1'b1;
      step();
      check("t6_rst_outs", {busy, core_start, ser_load, ser_advance, ks_valid, ks_last, done, err}, 0);
      check("t6_rst_ctr", core_ctr, 0);
      rst = 1'b0;
      run_msg(4, 32'd5, 5, 0, 0);
      check("t6_adv", n_adv, 4);
      check("t6_last", last_at, 4);
      check("t6_ctr", cs_ctr[0], 5);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
